// File: rtl/bakraid_eeprom_93c66_if.sv
// Storage-side bus of the 93C66 responder: word address, write data/strobe
// and the 1-cycle-latency read data returned by the external RAM.
interface bakraid_eeprom_93c66_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
);
    logic [ADDR_W-1:0] MEM_ADDR;
    logic [DATA_W-1:0] MEM_WDATA;
    logic              MEM_WE;
    logic [DATA_W-1:0] MEM_RDATA;

    modport master (output MEM_ADDR, output MEM_WDATA, output MEM_WE, input MEM_RDATA);
    modport slave  (input MEM_ADDR, input MEM_WDATA, input MEM_WE, output MEM_RDATA);
endinterface

// File: rtl/bakraid_eeprom_93c66.sv
// 93C66 (x16) serial EEPROM responder: decodes the bit-banged SCS/SCLK/SDI
// stream from the 68K side and serves/programs words in an external RAM.
module bakraid_eeprom_93c66 #(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 16,
    parameter int BUSY_CYCLES = 64
) (
    input  logic CLK,
    input  logic RESET,
    input  logic SCS,
    input  logic SCLK,
    input  logic SDI,
    output logic SDO,
    bakraid_eeprom_93c66_if.master mem,
    output logic BUSY,
    output logic WREN
);
    // Extra cycles cover the SCS resync so the master sees a full busy window
    localparam int BUSY_LOAD = BUSY_CYCLES + 8;
    localparam int BC_W      = $clog2(BUSY_LOAD + 1);
    localparam int CNT_W     = $clog2(ADDR_W + DATA_W + 2);

    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_RD_FETCH, S_RD_SHIFT, S_WR_DATA, S_PROG_WAIT, S_PROG, S_IGNORE
    } state_t;

    state_t            r_state, n_state;
    logic [1:0]        r_scs_s, r_sclk_s, r_sdi_s;
    logic              r_sclk_d;
    logic [CNT_W-1:0]  r_cnt, n_cnt;
    logic [ADDR_W:0]   r_cmd, n_cmd;
    logic [ADDR_W-1:0] r_addr, n_addr;
    logic [DATA_W-1:0] r_data, n_data;
    logic [DATA_W-1:0] r_dout, n_dout;
    logic [1:0]        r_fetch, n_fetch;
    logic              r_bulk, n_bulk;
    logic              r_sdo, n_sdo;
    logic              r_we, n_we;
    logic [ADDR_W-1:0] r_maddr, n_maddr;
    logic [DATA_W-1:0] r_wdata, n_wdata;
    logic              r_busy, n_busy;
    logic              r_wren, n_wren;
    logic [BC_W-1:0]   r_bcnt, n_bcnt;

    logic              w_scs, w_sdi, w_rise, w_smp;
    logic [ADDR_W+1:0] w_cmd;
    logic [1:0]        w_op;
    logic [ADDR_W-1:0] w_a;

    assign w_scs  = r_scs_s[1];
    assign w_sdi  = r_sdi_s[1];
    assign w_rise = r_sclk_s[1] & ~r_sclk_d;
    assign w_smp  = w_rise & w_scs;
    assign w_cmd  = {r_cmd, w_sdi};
    assign w_op   = w_cmd[ADDR_W+1:ADDR_W];
    assign w_a    = w_cmd[ADDR_W-1:0];

    assign SDO           = r_sdo;
    assign BUSY          = r_busy;
    assign WREN          = r_wren;
    assign mem.MEM_ADDR  = r_maddr;
    assign mem.MEM_WDATA = r_wdata;
    assign mem.MEM_WE    = r_we;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state  <= S_IDLE;
            r_scs_s  <= '0;
            r_sclk_s <= '0;
            r_sdi_s  <= '0;
            r_sclk_d <= 1'b0;
            r_cnt    <= '0;
            r_cmd    <= '0;
            r_addr   <= '0;
            r_data   <= '0;
            r_dout   <= '0;
            r_fetch  <= '0;
            r_bulk   <= 1'b0;
            r_sdo    <= 1'b1;
            r_we     <= 1'b0;
            r_maddr  <= '0;
            r_wdata  <= '0;
            r_busy   <= 1'b0;
            r_wren   <= 1'b0;
            r_bcnt   <= '0;
        end else begin
            r_state  <= n_state;
            r_scs_s  <= {r_scs_s[0], SCS};
            r_sclk_s <= {r_sclk_s[0], SCLK};
            r_sdi_s  <= {r_sdi_s[0], SDI};
            r_sclk_d <= r_sclk_s[1];
            r_cnt    <= n_cnt;
            r_cmd    <= n_cmd;
            r_addr   <= n_addr;
            r_data   <= n_data;
            r_dout   <= n_dout;
            r_fetch  <= n_fetch;
            r_bulk   <= n_bulk;
            r_sdo    <= n_sdo;
            r_we     <= n_we;
            r_maddr  <= n_maddr;
            r_wdata  <= n_wdata;
            r_busy   <= n_busy;
            r_wren   <= n_wren;
            r_bcnt   <= n_bcnt;
        end
    end

    always_comb begin
        n_state = r_state;
        n_cnt   = r_cnt;
        n_cmd   = r_cmd;
        n_addr  = r_addr;
        n_data  = r_data;
        n_dout  = r_dout;
        n_fetch = r_fetch;
        n_bulk  = r_bulk;
        n_sdo   = 1'b1;
        n_we    = r_we;
        n_maddr = r_maddr;
        n_wdata = r_wdata;
        n_busy  = r_busy;
        n_wren  = r_wren;
        n_bcnt  = r_bcnt;

        // RAM data is valid two edges after the address register is loaded
        if (r_fetch != 2'd0) begin
            n_fetch = r_fetch - 2'd1;
            if (r_fetch == 2'd1)
                n_dout = mem.MEM_RDATA;
        end

        case (r_state)
            S_IDLE: begin
                if (w_smp && w_sdi) begin
                    n_state = S_CMD;
                    n_cnt   = '0;
                end
            end
            S_CMD: begin
                if (!w_scs) begin
                    n_state = S_IDLE;
                end else if (w_smp) begin
                    n_cmd = {r_cmd[ADDR_W-1:0], w_sdi};
                    n_cnt = r_cnt + 1'b1;
                    if (r_cnt == CNT_W'(ADDR_W + 1)) begin
                        n_cnt  = '0;
                        n_addr = w_a;
                        n_data = '1;
                        n_bulk = 1'b0;
                        case (w_op)
                            2'b10: begin
                                n_state = S_RD_FETCH;
                                n_maddr = w_a;
                                n_fetch = 2'd2;
                                n_sdo   = 1'b0;
                            end
                            2'b01:   n_state = S_WR_DATA;
                            2'b11:   n_state = S_PROG_WAIT;
                            default: begin
                                case (w_a[ADDR_W-1 -: 2])
                                    2'b11: begin
                                        n_wren  = 1'b1;
                                        n_state = S_IGNORE;
                                    end
                                    2'b00: begin
                                        n_wren  = 1'b0;
                                        n_state = S_IGNORE;
                                    end
                                    2'b10: begin
                                        n_bulk  = 1'b1;
                                        n_state = S_PROG_WAIT;
                                    end
                                    default: begin
                                        n_bulk  = 1'b1;
                                        n_state = S_WR_DATA;
                                    end
                                endcase
                            end
                        endcase
                    end
                end
            end
            S_RD_FETCH: begin
                if (!w_scs) begin
                    n_state = S_IDLE;
                end else begin
                    n_sdo = 1'b0;
                    if (r_fetch == 2'd1) begin
                        n_state = S_RD_SHIFT;
                        n_cnt   = '0;
                    end
                end
            end
            S_RD_SHIFT: begin
                if (!w_scs) begin
                    n_state = S_IDLE;
                end else begin
                    n_sdo = r_sdo;
                    if (w_smp) begin
                        n_sdo  = r_dout[DATA_W-1];
                        n_dout = {r_dout[DATA_W-2:0], 1'b0};
                        n_cnt  = r_cnt + 1'b1;
                        // Last bit of this word is out: prefetch the next one
                        if (r_cnt == CNT_W'(DATA_W - 1)) begin
                            n_cnt   = '0;
                            n_addr  = r_addr + 1'b1;
                            n_maddr = r_addr + 1'b1;
                            n_fetch = 2'd2;
                        end
                    end
                end
            end
            S_WR_DATA: begin
                if (!w_scs) begin
                    n_state = S_IDLE;
                end else if (w_smp) begin
                    n_data = {r_data[DATA_W-2:0], w_sdi};
                    n_cnt  = r_cnt + 1'b1;
                    if (r_cnt == CNT_W'(DATA_W - 1))
                        n_state = S_PROG_WAIT;
                end
            end
            S_PROG_WAIT: begin
                if (!w_scs) begin
                    if (r_wren) begin
                        n_state = S_PROG;
                        n_busy  = 1'b1;
                        n_bcnt  = BC_W'(BUSY_LOAD);
                        n_we    = 1'b1;
                        n_maddr = r_bulk ? '0 : r_addr;
                        n_wdata = r_data;
                    end else begin
                        n_state = S_IDLE;
                    end
                end
            end
            S_PROG: begin
                n_sdo = ~w_scs;
                if (r_bcnt != '0)
                    n_bcnt = r_bcnt - 1'b1;
                if (r_we) begin
                    if (r_bulk && (r_maddr != '1))
                        n_maddr = r_maddr + 1'b1;
                    else
                        n_we = 1'b0;
                end else if (r_bcnt == '0) begin
                    n_busy  = 1'b0;
                    n_state = S_IDLE;
                    n_sdo   = 1'b1;
                end
            end
            S_IGNORE: begin
                if (!w_scs)
                    n_state = S_IDLE;
            end
            default: n_state = S_IDLE;
        endcase
    end
endmodule
